mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single shared memory of the multi-cycle CPU. Port 0 is the CPU control path (instruction fetch, LW, SW) and port 1 is the I/O / DMA requester. The block serialises both onto one fixed-latency memory port and returns read data with an acknowledge pulse. It gives CPU priority, with a starvation bound that guarantees I/O service.

---
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter and sequencer for the single shared memory of the
// multi-cycle CPU. Port "cpu" (fetch / LW / SW) normally has priority; port
// "io" (I/O / DMA) is guaranteed service after MAX_WAIT consecutive losses.
// Each accepted request runs ISSUE -> WAIT (MEM_LAT cycles) -> RESP and
// then returns to IDLE, where the next request is sampled.
//
// Ports
//   CLK, Reset                   clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata        CPU request (level, held until ack)
//   cpu_gnt, cpu_ack             CPU grant / completion pulses
//   io_req/we/addr/wdata         I/O request (level, held until ack)
//   io_gnt, io_ack               I/O grant / completion pulses
//   rdata                        captured read data, valid with an ack
//   busy                         high in every non-IDLE state
//   mem_en, mem_we               memory strobe / write enable (ISSUE only)
//   mem_addr, mem_wdata          memory address / write data
//   mem_rdata                    memory read data, MEM_LAT cycles after mem_en
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int MEM_LAT  = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_ack,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic              io_gnt,
   output logic              io_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic [2:0] LAT_INIT  = 3'(MEM_LAT);
   localparam logic [3:0] STARV_MAX = 4'(MAX_WAIT);

   logic [1:0]        state_q,     state_d;
   logic [2:0]        lat_q,       lat_d;
   logic [3:0]        starv_q,     starv_d;
   logic              owner_q,     owner_d;     // 0 = CPU, 1 = I/O
   logic              we_q,        we_d;
   logic              cpu_gnt_q,   cpu_gnt_d;
   logic              io_gnt_q,    io_gnt_d;
   logic              cpu_ack_q,   cpu_ack_d;
   logic              io_ack_q,    io_ack_d;
   logic              busy_q,      busy_d;
   logic              mem_en_q,    mem_en_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rdata_q,     rdata_d;
   logic              pick_io_s;

   // Next-state, arbitration and registered-output computation
   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      starv_d     = starv_q;
      owner_d     = owner_q;
      we_d        = we_q;
      cpu_gnt_d   = 1'b0;
      io_gnt_d    = 1'b0;
      cpu_ack_d   = 1'b0;
      io_ack_d    = 1'b0;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      pick_io_s   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cpu_req || io_req) begin
               // CPU wins contention until I/O has lost MAX_WAIT times in a
               // row; the loss counter saturates there and any I/O win clears it.
               if (cpu_req && io_req) begin
                  if (starv_q < STARV_MAX) begin
                     pick_io_s = 1'b0;
                     starv_d   = starv_q + 4'd1;
                  end else begin
                     pick_io_s = 1'b1;
                     starv_d   = 4'd0;
                  end
               end else if (io_req) begin
                  pick_io_s = 1'b1;
                  starv_d   = 4'd0;
               end else begin
                  pick_io_s = 1'b0;
               end

               owner_d     = pick_io_s;
               we_d        = pick_io_s ? io_we    : cpu_we;
               mem_addr_d  = pick_io_s ? io_addr  : cpu_addr;
               mem_wdata_d = pick_io_s ? io_wdata : cpu_wdata;
               mem_en_d    = 1'b1;
               mem_we_d    = pick_io_s ? io_we    : cpu_we;
               cpu_gnt_d   = ~pick_io_s;
               io_gnt_d    = pick_io_s;
               state_d     = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ISSUE: begin
            lat_d   = LAT_INIT;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            // Last WAIT cycle: read data is valid now, so capture it together
            // with raising the ack for the RESP cycle.
            if (lat_q <= 3'd1) begin
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end else begin
                  rdata_d = rdata_q;
               end
               cpu_ack_d = ~owner_q;
               io_ack_d  = owner_q;
               lat_d     = 3'd0;
               state_d   = ST_RESP;
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs, cleared asynchronously by Reset
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         lat_q       <= 3'd0;
         starv_q     <= 4'd0;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         cpu_gnt_q   <= 1'b0;
         io_gnt_q    <= 1'b0;
         cpu_ack_q   <= 1'b0;
         io_ack_q    <= 1'b0;
         busy_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         starv_q     <= starv_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         cpu_gnt_q   <= cpu_gnt_d;
         io_gnt_q    <= io_gnt_d;
         cpu_ack_q   <= cpu_ack_d;
         io_ack_q    <= io_ack_d;
         busy_q      <= busy_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   assign cpu_gnt   = cpu_gnt_q;
   assign io_gnt    = io_gnt_q;
   assign cpu_ack   = cpu_ack_q;
   assign io_ack    = io_ack_q;
   assign busy      = busy_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Three arbiters (MEM_LAT = 1, 3, 2; MAX_WAIT = 4) share clock and reset.
// Each has a latency-accurate memory stub and a transaction-level model that
// predicts every output each cycle; directed tests add literal expectations.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   logic CLK = 1'b0;
   logic Reset;

   logic [2:0]       cpu_req, cpu_we, cpu_gnt, cpu_ack;
   logic [2:0]       io_req, io_we, io_gnt, io_ack;
   logic [2:0]       busy, mem_en, mem_we;
   logic [2:0][15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
   logic [2:0][15:0] rdata, mem_addr, mem_wdata, mem_rdata;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always #5 CLK = ~CLK;

   // free-running cycle count, used to make non-read memory data distinctive
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [15:0] memf(input logic [15:0] a);
      case (a)
         16'h0010: memf = 16'hBEEF;
         16'h0030: memf = 16'hCAFE;
         default:  memf = a ^ 16'h5A5A;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);

      mem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(LAT), .MAX_WAIT(4)) u_dut (
         .CLK(CLK), .Reset(Reset),
         .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
         .cpu_gnt(cpu_gnt[g]), .cpu_ack(cpu_ack[g]),
         .io_req(io_req[g]), .io_we(io_we[g]), .io_addr(io_addr[g]), .io_wdata(io_wdata[g]),
         .io_gnt(io_gnt[g]), .io_ack(io_ack[g]),
         .rdata(rdata[g]), .busy(busy[g]),
         .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
         .mem_rdata(mem_rdata[g])
      );

      // memory stub: read data appears exactly LAT cycles after the strobe,
      // every other cycle carries junk so a mistimed capture is visible
      logic [15:0] pipe [LAT];
      always @(posedge CLK) begin
         pipe[0] <= (mem_en[g] && !mem_we[g]) ? memf(mem_addr[g]) : {8'hEE, cyc[7:0]};
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign mem_rdata[g] = pipe[LAT-1];

      // transaction model: m_k is the cycle offset since the sampling IDLE cycle
      bit        m_act, m_owner, m_we;
      int        m_k, m_starv;
      bit [15:0] m_addr, m_wdata, m_rdata;
      always @(posedge CLK or posedge Reset) begin
         if (Reset) begin
            m_act <= 1'b0; m_k <= 0; m_starv <= 0; m_rdata <= 16'h0000;
            m_owner <= 1'b0; m_we <= 1'b0; m_addr <= 16'h0000; m_wdata <= 16'h0000;
         end else if (!m_act) begin
            if (cpu_req[g] || io_req[g]) begin
               bit win_io;
               if (cpu_req[g] && io_req[g]) begin
                  win_io = (m_starv >= 4);
                  m_starv <= win_io ? 0 : m_starv + 1;
               end else begin
                  win_io = io_req[g];
                  if (win_io) m_starv <= 0;
               end
               m_owner <= win_io;
               m_we    <= win_io ? io_we[g]    : cpu_we[g];
               m_addr  <= win_io ? io_addr[g]  : cpu_addr[g];
               m_wdata <= win_io ? io_wdata[g] : cpu_wdata[g];
               m_act   <= 1'b1;
               m_k     <= 1;
            end
         end else begin
            if (m_k == LAT + 1 && !m_we) m_rdata <= memf(m_addr);
            if (m_k == LAT + 2) begin
               m_act <= 1'b0;
               m_k   <= 0;
            end else begin
               m_k <= m_k + 1;
            end
         end
      end

      // per-cycle comparison against the model, away from the active edge
      always @(negedge CLK) begin
         bit issue, resp;
         issue = m_act && (m_k == 1);
         resp  = m_act && (m_k == LAT + 2);
         chk($sformatf("i%0d cpu_gnt", g), 32'(cpu_gnt[g]), 32'(issue && !m_owner));
         chk($sformatf("i%0d io_gnt",  g), 32'(io_gnt[g]),  32'(issue && m_owner));
         chk($sformatf("i%0d cpu_ack", g), 32'(cpu_ack[g]), 32'(resp && !m_owner));
         chk($sformatf("i%0d io_ack",  g), 32'(io_ack[g]),  32'(resp && m_owner));
         chk($sformatf("i%0d mem_en",  g), 32'(mem_en[g]),  32'(issue));
         chk($sformatf("i%0d mem_we",  g), 32'(mem_we[g]),  32'(issue && m_we));
         chk($sformatf("i%0d busy",    g), 32'(busy[g]),    32'(m_act));
         chk($sformatf("i%0d rdata",   g), 32'(rdata[g]),   32'(m_rdata));
         if (issue) begin
            chk($sformatf("i%0d mem_addr",  g), 32'(mem_addr[g]),  32'(m_addr));
            chk($sformatf("i%0d mem_wdata", g), 32'(mem_wdata[g]), 32'(m_wdata));
         end
      end
   end

   // One requester: raise req, hold until ack, drop during the ack cycle.
   task automatic requester(input int inst, input int port, input int n,
                            input logic we, input logic [15:0] addr);
      for (int i = 0; i < n; i++) begin
         bit seen;
         seen = 1'b0;
         if (port == 0) begin
            cpu_we[inst] = we; cpu_addr[inst] = addr + 16'(i);
            cpu_wdata[inst] = 16'hA000 + 16'(i); cpu_req[inst] = 1'b1;
         end else begin
            io_we[inst] = we; io_addr[inst] = addr + 16'(i);
            io_wdata[inst] = 16'hB000 + 16'(i); io_req[inst] = 1'b1;
         end
         for (int c = 0; c < 80 && !seen; c++) begin
            @(negedge CLK);
            seen = (port == 0) ? cpu_ack[inst] : io_ack[inst];
         end
         if (port == 0) cpu_req[inst] = 1'b0;
         else           io_req[inst]  = 1'b0;
         chk($sformatf("ack_seen i%0d p%0d", inst, port), 32'(seen), 32'd1);
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] seq;
      int ng, t_cg, t_ack, t_ig, lat_seen;

      Reset = 1'b1;
      cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
      io_req  = '0; io_we  = '0; io_addr  = '0; io_wdata  = '0;
      repeat (3) @(posedge CLK);
      #1 Reset = 1'b0;

      // reset state
      @(negedge CLK);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rst busy i%0d", g),   32'(busy[g]),   32'd0);
         chk($sformatf("rst rdata i%0d", g),  32'(rdata[g]),  32'd0);
         chk($sformatf("rst mem_en i%0d", g), 32'(mem_en[g]), 32'd0);
         chk($sformatf("rst pulses i%0d", g),
             32'({cpu_gnt[g], io_gnt[g], cpu_ack[g], io_ack[g]}), 32'd0);
      end

      // CPU read, MEM_LAT=1 (instance 0)
      @(posedge CLK); #1;
      cpu_we[0] = 1'b0; cpu_addr[0] = 16'h0010; cpu_req[0] = 1'b1;
      @(negedge CLK); chk("t1 c0 gnt", 32'(cpu_gnt[0]), 32'd0);
      @(negedge CLK); chk("t1 c1 gnt", 32'(cpu_gnt[0]), 32'd1);
                      chk("t1 c1 mem_en", 32'(mem_en[0]), 32'd1);
                      chk("t1 c1 mem_addr", 32'(mem_addr[0]), 32'h0010);
      @(negedge CLK); chk("t1 c2 ack", 32'(cpu_ack[0]), 32'd0);
      @(negedge CLK); chk("t1 c3 ack", 32'(cpu_ack[0]), 32'd1);
                      chk("t1 c3 rdata", 32'(rdata[0]), 32'hBEEF);
                      cpu_req[0] = 1'b0;
      @(negedge CLK); chk("t1 c4 busy", 32'(busy[0]), 32'd0);

      // read then I/O write, MEM_LAT=2 (instance 2)
      @(posedge CLK); #1;
      requester(2, 0, 1, 1'b0, 16'h0010);
      io_we[2] = 1'b1; io_addr[2] = 16'h0020; io_wdata[2] = 16'h1234; io_req[2] = 1'b1;
      @(negedge CLK);
      @(negedge CLK); chk("t2 gnt", 32'(io_gnt[2]), 32'd1);
                      chk("t2 mem_we", 32'(mem_we[2]), 32'd1);
                      chk("t2 mem_wdata", 32'(mem_wdata[2]), 32'h1234);
                      chk("t2 mem_addr", 32'(mem_addr[2]), 32'h0020);
      @(negedge CLK); chk("t2 mem_we after", 32'(mem_we[2]), 32'd0);
      @(negedge CLK); chk("t2 early ack", 32'(io_ack[2]), 32'd0);
      @(negedge CLK); chk("t2 ack", 32'(io_ack[2]), 32'd1);
                      chk("t2 rdata kept", 32'(rdata[2]), 32'hBEEF);
                      io_req[2] = 1'b0;
      @(posedge CLK); #1;

      // simultaneous requests (instance 0)
      t_cg = -1; t_ack = -1; t_ig = -1;
      fork
         requester(0, 0, 1, 1'b0, 16'h0060);
         requester(0, 1, 1, 1'b0, 16'h0070);
         for (int c = 0; c < 60 && !io_ack[0]; c++) begin
            @(negedge CLK);
            if (cpu_gnt[0]) t_cg  = c;
            if (cpu_ack[0]) t_ack = c;
            if (io_gnt[0])  t_ig  = c;
         end
      join
      chk("t3 cpu gnt cycle", 32'(t_cg), 32'd1);
      chk("t3 io gnt after ack", 32'(t_ig - t_ack), 32'd2);

      // starvation bound MAX_WAIT=4 (instance 0)
      seq = 8'h00; ng = 0;
      fork
         requester(0, 0, 6, 1'b0, 16'h0040);
         requester(0, 1, 2, 1'b0, 16'h0050);
         for (int c = 0; c < 200 && ng < 8; c++) begin
            @(negedge CLK);
            if (cpu_gnt[0] || io_gnt[0]) begin
               seq = {seq[6:0], io_gnt[0]};
               ng++;
            end
         end
      join
      chk("t4 grant order", 32'(seq), 32'h09);
      chk("t4 grant count", 32'(ng), 32'd8);

      // latency, MEM_LAT=3 (instance 1)
      lat_seen = -1;
      cpu_we[1] = 1'b0; cpu_addr[1] = 16'h0030; cpu_req[1] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (cpu_ack[1]) begin
            lat_seen = c;
            break;
         end
      end
      cpu_req[1] = 1'b0;
      chk("t5 ack cycle", 32'(lat_seen), 32'd5);
      chk("t5 rdata", 32'(rdata[1]), 32'hCAFE);
      @(posedge CLK); #1;

      // Reset during WAIT (instance 1)
      cpu_we[1] = 1'b0; cpu_addr[1] = 16'h0030; cpu_req[1] = 1'b1;
      @(negedge CLK);
      @(negedge CLK); chk("t6 gnt", 32'(cpu_gnt[1]), 32'd1);
      @(negedge CLK); #1 Reset = 1'b1;
      #1;
      chk("t6 busy", 32'(busy[1]), 32'd0);
      chk("t6 mem_en", 32'(mem_en[1]), 32'd0);
      chk("t6 ack", 32'(cpu_ack[1]), 32'd0);
      chk("t6 rdata", 32'(rdata[1]), 32'd0);
      cpu_req[1] = 1'b0;
      @(posedge CLK); #1 Reset = 1'b0;
      cpu_addr[1] = 16'h0044; cpu_req[1] = 1'b1;
      @(negedge CLK); chk("t6 post c0 gnt", 32'(cpu_gnt[1]), 32'd0);
                      chk("t6 post c0 ack", 32'(cpu_ack[1]), 32'd0);
      @(negedge CLK); chk("t6 post c1 gnt", 32'(cpu_gnt[1]), 32'd1);
      for (int c = 0; c < 20 && !cpu_ack[1]; c++) @(negedge CLK);
      cpu_req[1] = 1'b0;
      chk("t6 post rdata", 32'(rdata[1]), 32'h5A1E);
      @(posedge CLK); #1;
      repeat (3) @(negedge CLK);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
